// File: rtl/receipt_integrity_checker.sv
// receipt_integrity_checker: checks one mu-ledger receipt per valid cycle.
// Recomputes the instruction cost from a fixed table, verifies
// post = pre + cost (no 32-bit overflow) and, in chain mode, that pre
// continues the previous receipt's post. All outputs are registered and
// hold while receipt_valid is low.
// Optional build macro: RIC_STRICT_OPCODE_EN -- opcodes outside the table
// (0x07..0xFE) are rejected with error 0x05 and report a cost of 0.
module receipt_integrity_checker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        receipt_valid,
  input  logic [31:0] receipt_pre_mu,
  input  logic [31:0] receipt_post_mu,
  input  logic [7:0]  receipt_opcode,
  input  logic [31:0] receipt_operand,
  input  logic        chain_mode,
  input  logic [31:0] prev_post_mu,
  output logic        receipt_integrity_ok,
  output logic        chain_continuity_ok,
  output logic [31:0] computed_cost,
  output logic [7:0]  error_code
);

  localparam logic [7:0] ErrNone     = 8'h00;
  localparam logic [7:0] ErrCost     = 8'h01;
  localparam logic [7:0] ErrChain    = 8'h02;
  localparam logic [7:0] ErrOverflow = 8'h03;
  localparam logic [7:0] ErrNonMono  = 8'h04;
  localparam logic [7:0] ErrUnknown  = 8'h05;

  logic [31:0] cost;
  logic        unknown_op;
  logic [32:0] sum;
  logic        overflow;
  logic        non_mono;
  logic        cost_mismatch;
  logic        chain_break;

  logic        integrity_ok_d, integrity_ok_q;
  logic        continuity_ok_d, continuity_ok_q;
  logic [31:0] cost_d, cost_q;
  logic [7:0]  error_d, error_q;

  // Cost table lookup; op8 is the generic cost for unlisted opcodes.
  always_comb begin
    cost       = 32'd0;
    unknown_op = 1'b0;
    case (receipt_opcode)
      8'h00:   cost = 32'd8;
      8'h01:   cost = 32'd4 + {24'd0, receipt_operand[7:0]};
      8'h02:   cost = 32'd4 + {24'd0, receipt_operand[7:0]};
      8'h03:   cost = {24'd0, receipt_operand[7:0]};
      8'h04:   cost = 32'd1;
      8'h05:   cost = {24'd0, receipt_operand[7:0]};
      8'h06:   cost = {16'd0, receipt_operand[15:0]};
      8'hFF:   cost = 32'd0;
      default: begin
`ifdef RIC_STRICT_OPCODE_EN
        unknown_op = 1'b1;
        cost       = 32'd0;
`else
        cost       = {24'd0, receipt_operand[7:0]};
`endif
      end
    endcase
  end

  // Individual checks on the current receipt fields.
  always_comb begin
    sum           = {1'b0, receipt_pre_mu} + {1'b0, cost};
    overflow      = sum[32];
    non_mono      = receipt_post_mu < receipt_pre_mu;
    cost_mismatch = sum[31:0] != receipt_post_mu;
    chain_break   = chain_mode && (receipt_pre_mu != prev_post_mu);
  end

  // Next-state: load a fresh verdict on valid receipts, otherwise hold.
  always_comb begin
    integrity_ok_d  = integrity_ok_q;
    continuity_ok_d = continuity_ok_q;
    cost_d          = cost_q;
    error_d         = error_q;
    if (receipt_valid) begin
      integrity_ok_d  = !overflow && !cost_mismatch && !unknown_op;
      continuity_ok_d = !chain_break;
      cost_d          = cost;
      if (overflow)           error_d = ErrOverflow;
      else if (unknown_op)    error_d = ErrUnknown;
      else if (non_mono)      error_d = ErrNonMono;
      else if (cost_mismatch) error_d = ErrCost;
      else if (chain_break)   error_d = ErrChain;
      else                    error_d = ErrNone;
    end
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integrity_ok_q  <= 1'b0;
      continuity_ok_q <= 1'b0;
      cost_q          <= 32'd0;
      error_q         <= 8'd0;
    end else begin
      integrity_ok_q  <= integrity_ok_d;
      continuity_ok_q <= continuity_ok_d;
      cost_q          <= cost_d;
      error_q         <= error_d;
    end
  end

  assign receipt_integrity_ok = integrity_ok_q;
  assign chain_continuity_ok  = continuity_ok_q;
  assign computed_cost        = cost_q;
  assign error_code           = error_q;

endmodule

// File: tb/tb_receipt_integrity_checker.sv
// Bench for receipt_integrity_checker: a spec-level model tracks the expected
// outputs and is compared every cycle; directed receipts add literal checks.
module tb_receipt_integrity_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        receipt_valid = 1'b0;
  logic [31:0] receipt_pre_mu = '0;
  logic [31:0] receipt_post_mu = '0;
  logic [7:0]  receipt_opcode = '0;
  logic [31:0] receipt_operand = '0;
  logic        chain_mode = 1'b0;
  logic [31:0] prev_post_mu = '0;
  logic        receipt_integrity_ok;
  logic        chain_continuity_ok;
  logic [31:0] computed_cost;
  logic [7:0]  error_code;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  receipt_integrity_checker dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .receipt_valid       (receipt_valid),
    .receipt_pre_mu      (receipt_pre_mu),
    .receipt_post_mu     (receipt_post_mu),
    .receipt_opcode      (receipt_opcode),
    .receipt_operand     (receipt_operand),
    .chain_mode          (chain_mode),
    .prev_post_mu        (prev_post_mu),
    .receipt_integrity_ok(receipt_integrity_ok),
    .chain_continuity_ok (chain_continuity_ok),
    .computed_cost       (computed_cost),
    .error_code          (error_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        cont;
    logic [31:0] cost;
    logic [7:0]  err;
  } verdict_t;

  // Spec-level model: plain arithmetic on wide integers.
  function automatic verdict_t model(input longint pre, input longint post,
                                     input int op, input longint operand,
                                     input bit cm, input longint prev);
    verdict_t v;
    longint   c;
    longint   s;
    bit       unk;
    longint   op8;
    op8 = operand % 256;
    unk = 1'b0;
    if (op == 0) c = 8;
    else if (op == 1 || op == 2) c = 4 + op8;
    else if (op == 3 || op == 5) c = op8;
    else if (op == 4) c = 1;
    else if (op == 6) c = operand % 65536;
    else if (op == 255) c = 0;
    else begin
`ifdef RIC_STRICT_OPCODE_EN
      unk = 1'b1;
      c   = 0;
`else
      c   = op8;
`endif
    end
    s      = pre + c;
    v.cost = c[31:0];
    v.ok   = (s <= 64'hFFFF_FFFF) && (s == post) && !unk;
    v.cont = !cm || (pre == prev);
    if (s > 64'hFFFF_FFFF) v.err = 8'h03;
    else if (unk)          v.err = 8'h05;
    else if (post < pre)   v.err = 8'h04;
    else if (s != post)    v.err = 8'h01;
    else if (!v.cont)      v.err = 8'h02;
    else                   v.err = 8'h00;
    return v;
  endfunction

  verdict_t exp_q;

  // Expected-output register driven by the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else if (receipt_valid)
      exp_q <= model(longint'(receipt_pre_mu), longint'(receipt_post_mu),
                     int'(receipt_opcode), longint'(receipt_operand),
                     chain_mode, longint'(prev_post_mu));
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({receipt_integrity_ok, chain_continuity_ok, computed_cost, error_code} !== exp_q) begin
        errors++;
        $display("FAIL model t=%0t got ok=%b cont=%b cost=%h err=%h expected ok=%b cont=%b cost=%h err=%h",
                 $time, receipt_integrity_ok, chain_continuity_ok, computed_cost, error_code,
                 exp_q.ok, exp_q.cont, exp_q.cost, exp_q.err);
      end
    end
  end

  // Drive one cycle of inputs; returns on the falling edge after the sampling edge.
  task automatic apply(input bit v, input logic [31:0] pre, input logic [31:0] post,
                       input logic [7:0] op, input logic [31:0] operand,
                       input bit cm, input logic [31:0] prev);
    receipt_valid   = v;
    receipt_pre_mu  = pre;
    receipt_post_mu = post;
    receipt_opcode  = op;
    receipt_operand = operand;
    chain_mode      = cm;
    prev_post_mu    = prev;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input bit ok, input bit cont,
                     input logic [31:0] cost, input logic [7:0] err);
    checks++;
    if (receipt_integrity_ok !== ok || chain_continuity_ok !== cont ||
        computed_cost !== cost || error_code !== err) begin
      errors++;
      $display("FAIL %s got ok=%b cont=%b cost=%h err=%h expected ok=%b cont=%b cost=%h err=%h",
               name, receipt_integrity_ok, chain_continuity_ok, computed_cost, error_code,
               ok, cont, cost, err);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lit("reset_state", 0, 0, 32'd0, 8'h00);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    apply(0, 32'd0, 32'd0, 8'h00, 32'd0, 0, 32'd0);
    lit("idle_after_reset", 0, 0, 32'd0, 8'h00);

    apply(1, 32'd0, 32'd8, 8'h00, 32'd0, 1, 32'd0);
    lit("pnew_pass", 1, 1, 32'd8, 8'h00);
    apply(1, 32'd100, 32'd110, 8'h01, 32'h10, 0, 32'd0);
    lit("psplit_forged", 0, 1, 32'd20, 8'h01);
    apply(1, 32'd100, 32'd120, 8'h01, 32'h10, 0, 32'd0);
    lit("psplit_ok", 1, 1, 32'd20, 8'h00);
    apply(1, 32'd50, 32'd51, 8'h04, 32'd0, 1, 32'd40);
    lit("chain_break", 1, 0, 32'd1, 8'h02);
    apply(1, 32'd50, 32'd51, 8'h04, 32'd0, 0, 32'd40);
    lit("chain_off", 1, 1, 32'd1, 8'h00);
    apply(1, 32'hFFFF_FFFF, 32'd0, 8'h04, 32'd0, 0, 32'd0);
    lit("overflow_pquery", 0, 1, 32'd1, 8'h03);
    apply(1, 32'hFFFF_FFFF, 32'd7, 8'h00, 32'd0, 0, 32'd0);
    lit("overflow_wrapped_post", 0, 1, 32'd8, 8'h03);
    apply(1, 32'd10, 32'd5, 8'h05, 32'd0, 0, 32'd0);
    lit("non_monotonic", 0, 1, 32'd0, 8'h04);
    apply(1, 32'd77, 32'd77, 8'hFF, 32'h1234, 1, 32'd77);
    lit("halt_zero_cost", 1, 1, 32'd0, 8'h00);
    // Back-to-back receipts, then hold with garbage inputs.
    apply(1, 32'd0, 32'h1234, 8'h06, 32'h00AB_1234, 0, 32'd0);
    lit("b2b_pdiscover", 1, 1, 32'h1234, 8'h00);
    apply(1, 32'd1, 32'h104, 8'h02, 32'h1FF, 0, 32'd0);
    lit("b2b_pmerge", 1, 1, 32'h103, 8'h00);
    apply(1, 32'd5, 32'h27, 8'h03, 32'h22, 1, 32'd5);
    lit("b2b_pmod", 1, 1, 32'h22, 8'h00);
    apply(0, 32'hFFFF_FFFF, 32'd3, 8'h01, 32'hFF, 1, 32'd9);
    lit("hold_1", 1, 1, 32'h22, 8'h00);
    apply(0, 32'd10, 32'd1, 8'h40, 32'h7, 1, 32'd2);
    lit("hold_2", 1, 1, 32'h22, 8'h00);
`ifdef RIC_STRICT_OPCODE_EN
    apply(1, 32'd0, 32'd5, 8'h40, 32'h05, 0, 32'd0);
    lit("unknown_opcode_strict", 0, 1, 32'd0, 8'h05);
`else
    apply(1, 32'd0, 32'd5, 8'h40, 32'h05, 0, 32'd0);
    lit("unknown_opcode_generic", 1, 1, 32'd5, 8'h00);
`endif
    // Asynchronous reset in the middle of a cycle.
    receipt_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 lit("mid_reset_clear", 0, 0, 32'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 32'd0, 32'd8, 8'h00, 32'd0, 1, 32'd0);
    lit("post_reset_idle", 0, 0, 32'd0, 8'h00);
    apply(1, 32'd0, 32'd8, 8'h00, 32'd0, 1, 32'd0);
    lit("post_reset_first", 1, 1, 32'd8, 8'h00);
    apply(0, 32'd0, 32'd0, 8'h00, 32'd0, 0, 32'd0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
